// File: rtl/display_scan_ctrl.sv
// Time-multiplexed N-digit 7-segment scan controller with a shared nibble output.
// Display data is double-buffered and only swapped at frame end, so no frame is ever torn.
module display_scan_ctrl #(
  parameter int N_DIGITS  = 4,
  parameter int DWELL_CYC = 4,
  parameter int DEAD_CYC  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  habilita,
  input  logic                  carrega,
  input  logic [4*N_DIGITS-1:0] valor,
  input  logic [N_DIGITS-1:0]   apaga,
  output logic [3:0]            nibble,
  output logic [N_DIGITS-1:0]   anodo,
  output logic                  fim_quadro,
  output logic                  pendente
);

  localparam int MAXC = (DWELL_CYC > DEAD_CYC) ? DWELL_CYC : DEAD_CYC;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int IW   = $clog2(N_DIGITS);
  localparam int VW   = 4 * N_DIGITS;

  localparam logic [CW-1:0] DEAD_LAST  = CW'(DEAD_CYC - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

  typedef enum logic [1:0] {S_OFF, S_BLANK, S_SHOW} state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [VW-1:0]       active_q, active_d;
  logic [VW-1:0]       shadow_q, shadow_d;
  logic                pend_q, pend_d;
  logic [3:0]          nibble_q, nibble_d;
  logic [N_DIGITS-1:0] anodo_q, anodo_d;
  logic                fim_q, fim_d;
  logic                last_show;

  assign last_show = (state_q == S_SHOW) && (idx_q == IDX_LAST) && (cnt_q == DWELL_LAST);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    if (!habilita) begin
      state_d = S_OFF;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_OFF: begin
          state_d = S_BLANK;
          idx_d   = '0;
          cnt_d   = '0;
        end
        S_BLANK: begin
          if (cnt_q == DEAD_LAST) begin
            state_d = S_SHOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_SHOW: begin
          if (cnt_q == DWELL_LAST) begin
            state_d = S_BLANK;
            cnt_d   = '0;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = S_OFF;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // While dark (off or being disabled) loads go straight through; otherwise they wait for frame end.
  always_comb begin
    active_d = active_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    if (!habilita || (state_q == S_OFF)) begin
      if (carrega) begin
        active_d = valor;
        shadow_d = valor;
        pend_d   = 1'b0;
      end else if (pend_q) begin
        active_d = shadow_q;
        pend_d   = 1'b0;
      end
    end else if (last_show) begin
      if (carrega) begin
        active_d = valor;
        shadow_d = valor;
      end else if (pend_q) begin
        active_d = shadow_q;
      end
      pend_d = 1'b0;
    end else if (carrega) begin
      shadow_d = valor;
      pend_d   = 1'b1;
    end
  end

  // Outputs are computed from next state so the registered values line up with state_q.
  always_comb begin
    nibble_d = 4'h0;
    anodo_d  = '0;
    fim_d    = 1'b0;
    if (state_d != S_OFF) begin
      nibble_d = active_d[{idx_d, 2'b00} +: 4];
    end
    if (state_d == S_SHOW) begin
      anodo_d = ({{(N_DIGITS-1){1'b0}}, 1'b1} << idx_d) & ~apaga;
      fim_d   = (idx_d == IDX_LAST) && (cnt_d == DWELL_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_OFF;
      idx_q    <= '0;
      cnt_q    <= '0;
      active_q <= '0;
      shadow_q <= '0;
      pend_q   <= 1'b0;
      nibble_q <= 4'h0;
      anodo_q  <= '0;
      fim_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      nibble_q <= nibble_d;
      anodo_q  <= anodo_d;
      fim_q    <= fim_d;
    end
  end

  assign nibble     = nibble_q;
  assign anodo      = anodo_q;
  assign fim_quadro = fim_q;
  assign pendente   = pend_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl: a frame-position model predicts every cycle's outputs.
module tb_display_scan_ctrl;
  localparam int N     = 4;
  localparam int DWELL = 4;
  localparam int DEAD  = 1;
  localparam int PER   = DEAD + DWELL;
  localparam int FRAME = N * PER;

  logic        clk = 1'b0;
  logic        rst_n, habilita, carrega;
  logic [15:0] valor;
  logic [3:0]  apaga;
  logic [3:0]  nibble;
  logic [3:0]  anodo;
  logic        fim_quadro, pendente;

  always #5 clk = ~clk;

  display_scan_ctrl #(.N_DIGITS(N), .DWELL_CYC(DWELL), .DEAD_CYC(DEAD)) dut (
    .clk(clk), .rst_n(rst_n), .habilita(habilita), .carrega(carrega),
    .valor(valor), .apaga(apaga), .nibble(nibble), .anodo(anodo),
    .fim_quadro(fim_quadro), .pendente(pendente)
  );

  typedef struct packed {
    logic [3:0] nib;
    logic [3:0] an;
    logic       fim;
    logic       pend;
  } exp_t;

  exp_t sbq[$];
  exp_t me;
  int   checks   = 0;
  int   failures = 0;

  // Model: m_en = scanning, m_pos = cycle position within the frame.
  bit          m_en   = 1'b0;
  int          m_pos  = 0;
  logic [15:0] m_act  = '0;
  logic [15:0] m_sh   = '0;
  bit          m_pend = 1'b0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic h, input logic c,
                      input logic [15:0] v, input logic [3:0] a);
    exp_t e;
    int   slot;
    int   ph;
    rst_n = r; habilita = h; carrega = c; valor = v; apaga = a;
    if (!r) begin
      m_en = 0; m_pos = 0; m_act = '0; m_sh = '0; m_pend = 0;
    end else begin
      if (!h || !m_en) begin
        if (c) begin m_act = v; m_sh = v; m_pend = 0; end
        else if (m_pend) begin m_act = m_sh; m_pend = 0; end
      end else if (m_pos == FRAME - 1) begin
        if (c) begin m_act = v; m_sh = v; end
        else if (m_pend) m_act = m_sh;
        m_pend = 0;
      end else if (c) begin
        m_sh = v; m_pend = 1;
      end
      if (!h) begin m_en = 0; m_pos = 0; end
      else if (m_en) m_pos = (m_pos + 1) % FRAME;
      else begin m_en = 1; m_pos = 0; end
    end
    e = '0;
    if (m_en) begin
      slot  = m_pos / PER;
      ph    = m_pos % PER;
      e.nib = m_act[slot*4 +: 4];
      if (ph >= DEAD) e.an = (4'b0001 << slot) & ~a;
      e.fim = (m_pos == FRAME - 1);
    end
    e.pend = m_pend;
    sbq.push_back(e);
    @(negedge clk);
  endtask

  task automatic run(input int n, input logic [3:0] a);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 16'h0, a);
  endtask

  task automatic wait_pos(input int p);
    for (int i = 0; i < 2 * FRAME && !(m_en && m_pos == p); i++)
      step(1'b1, 1'b1, 1'b0, 16'h0, 4'h0);
  endtask

  always @(posedge clk) begin
    #1;
    if (sbq.size() > 0) begin
      me = sbq.pop_front();
      chk("nibble",     {4'h0, nibble},     {4'h0, me.nib});
      chk("anodo",      {4'h0, anodo},      {4'h0, me.an});
      chk("fim_quadro", {7'h0, fim_quadro}, {7'h0, me.fim});
      chk("pendente",   {7'h0, pendente},   {7'h0, me.pend});
    end
  end

  always @(negedge clk) begin
    if ($time > 20) begin
      checks++;
      if (!$onehot0(anodo)) begin
        failures++;
        $display("FAIL anodo_onehot at %0t: got %b expected one-hot or zero", $time, anodo);
      end
    end
  end

  initial begin
    rst_n = 1'b0; habilita = 1'b0; carrega = 1'b0; valor = '0; apaga = '0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 16'h0, 4'h0);
    step(1'b1, 1'b0, 1'b1, 16'h4321, 4'h0);
    step(1'b1, 1'b0, 1'b0, 16'h0, 4'h0);
    run(2 * FRAME + 3, 4'h0);
    wait_pos(7);
    step(1'b1, 1'b1, 1'b1, 16'hABCD, 4'h0);
    run(2 * FRAME, 4'h0);
    wait_pos(FRAME - 1);
    step(1'b1, 1'b1, 1'b1, 16'h00F0, 4'h0);
    run(FRAME + 2, 4'h0);
    run(FRAME, 4'b0100);
    wait_pos(7);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 16'h0, 4'h0);
    run(FRAME + 5, 4'h0);
    wait_pos(3);
    step(1'b1, 1'b1, 1'b1, 16'h5555, 4'h0);
    run(5, 4'h0);
    step(1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
    run(FRAME + 5, 4'h0);
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 199) != 0),
           ($urandom_range(0, 29) != 0),
           ($urandom_range(0, 9) == 0),
           16'($urandom),
           ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0);
    end
    run(3, 4'h0);
    @(posedge clk);
    #3;
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
